seq_controller: RTL

Parametrised multi-cycle control unit for the simple CPU, replacing the fixed 8-register controller. It sequences fetch and execute of one instruction at a time and drives the datapath bus: register write enables, bus tri-state selects, ALU operation, PC increment and branch. It adds a memory-load instruction with a ready handshake, a HALT state, and per-instruction `done` / `halted` status. It sits between the instruction register and the register/ALU/bus datapath.

---
 rtl/seq_controller_pkg.sv | 46 ++++
 rtl/seq_controller_if.sv | 31 +++
 rtl/seq_controller_onehot_dec.sv | 17 +
 rtl/seq_controller.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_controller_pkg.sv
// Shared types and constants for the multi-cycle sequencing controller:
// state encoding, opcode values and the special-slot indices of the one-hot vectors.
package seq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_T1     = 3'd2,
        ST_T2     = 3'd3,
        ST_T3     = 3'd4,
        ST_MEMW   = 3'd5,
        ST_HALTED = 3'd6
    } state_t;

    localparam logic [2:0] OP_LDI  = 3'd0;
    localparam logic [2:0] OP_MOV  = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_LD   = 3'd4;
    localparam logic [2:0] OP_BEQZ = 3'd5;
    localparam logic [2:0] OP_JMP  = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    // Write-enable vector: Ri at 0..NREG-1, then A, then G.
    function automatic int idx_a(input int nreg);
        return nreg;
    endfunction

    function automatic int idx_g(input int nreg);
        return nreg + 1;
    endfunction

    // Bus-driver vector: Ri at 0..NREG-1, then G, IMM, MEM.
    function automatic int idx_tri_g(input int nreg);
        return nreg;
    endfunction

    function automatic int idx_imm(input int nreg);
        return nreg + 1;
    endfunction

    function automatic int idx_mem(input int nreg);
        return nreg + 2;
    endfunction

endpackage

// File: rtl/seq_controller_if.sv
// Bundle between the controller and the instruction register / datapath.
// The controller is the master: it consumes instruction and status, drives control.
interface seq_controller_if #(
  parameter int NREG = 8,
  parameter int IW   = 23
);
  logic            start;
  logic [IW-1:0]   code;
  logic            zero;
  logic            mem_ready;

  logic [NREG+1:0] r_en_oh;
  logic [NREG+2:0] tri_oh;
  logic            ir_ld;
  logic            inc_pc;
  logic            branch;
  logic            alu_op;
  logic            mem_req;
  logic            done;
  logic            halted;

  modport master (
    input  start, code, zero, mem_ready,
    output r_en_oh, tri_oh, ir_ld, inc_pc, branch, alu_op, mem_req, done, halted
  );

  modport slave (
    output start, code, zero, mem_ready,
    input  r_en_oh, tri_oh, ir_ld, inc_pc, branch, alu_op, mem_req, done, halted
  );
endinterface

// File: rtl/seq_controller_onehot_dec.sv
// Binary index to one-hot decoder with a global enable; indices >= N decode to all zeros.
module onehot_dec #(
  parameter  int N = 10,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [W-1:0] i_idx,
  input  logic         i_en,
  output logic [N-1:0] o_oh
);

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_bit
      assign o_oh[gi] = i_en && (i_idx == W'(gi));
    end
  endgenerate

endmodule

// File: rtl/seq_controller.sv
// Multi-cycle fetch/execute sequencer. The state register is the only storage;
// every output is decoded combinationally from state, code, zero and mem_ready.
module seq_controller
  import seq_ctrl_pkg::*;
#(
  parameter int NREG = 8,
  parameter int IW   = 23
) (
  input  logic             clk,
  input  logic             rst,
  seq_controller_if.master bus
);

  localparam int RSW = $clog2(NREG);
  localparam int RW  = $clog2(NREG + 2);
  localparam int TW  = $clog2(NREG + 3);

  localparam logic [RW-1:0] REN_A   = RW'(idx_a(NREG));
  localparam logic [RW-1:0] REN_G   = RW'(idx_g(NREG));
  localparam logic [TW-1:0] TRI_G   = TW'(idx_tri_g(NREG));
  localparam logic [TW-1:0] TRI_IMM = TW'(idx_imm(NREG));
  localparam logic [TW-1:0] TRI_MEM = TW'(idx_mem(NREG));

  state_t r_state;
  state_t w_state_next;

  logic [2:0]     w_op;
  logic [RSW-1:0] w_rx;
  logic [RSW-1:0] w_ry;
  logic           w_unused_imm;

  logic [RW-1:0]  w_ren_idx;
  logic           w_ren_en;
  logic [TW-1:0]  w_tri_idx;
  logic           w_tri_en;
  logic           w_ir_ld;
  logic           w_inc_pc;
  logic           w_branch;
  logic           w_alu_op;
  logic           w_mem_req;
  logic           w_done;
  logic           w_halted;

  logic [NREG+1:0] w_r_en_oh;
  logic [NREG+2:0] w_tri_oh;

  assign w_op = bus.code[IW-1 -: 3];
  assign w_rx = bus.code[IW-4 -: RSW];
  assign w_ry = bus.code[IW-4-RSW -: RSW];
  // The immediate is consumed by the datapath directly, not by the sequencer.
  assign w_unused_imm = ^bus.code[IW-4-2*RSW:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ren_idx    = '0;
    w_ren_en     = 1'b0;
    w_tri_idx    = '0;
    w_tri_en     = 1'b0;
    w_ir_ld      = 1'b0;
    w_inc_pc     = 1'b0;
    w_branch     = 1'b0;
    w_alu_op     = 1'b0;
    w_mem_req    = 1'b0;
    w_done       = 1'b0;
    w_halted     = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_state_next = ST_FETCH;
        end
      end

      ST_FETCH: begin
        w_ir_ld      = 1'b1;
        w_inc_pc     = 1'b1;
        w_state_next = ST_T1;
      end

      ST_T1: begin
        unique case (w_op)
          OP_LDI: begin
            w_tri_en     = 1'b1;
            w_tri_idx    = TRI_IMM;
            w_ren_en     = 1'b1;
            w_ren_idx    = RW'(w_rx);
            w_done       = 1'b1;
            w_state_next = ST_FETCH;
          end
          OP_MOV: begin
            w_tri_en     = 1'b1;
            w_tri_idx    = TW'(w_ry);
            w_ren_en     = 1'b1;
            w_ren_idx    = RW'(w_rx);
            w_done       = 1'b1;
            w_state_next = ST_FETCH;
          end
          OP_ADD, OP_SUB: begin
            w_tri_en     = 1'b1;
            w_tri_idx    = TW'(w_rx);
            w_ren_en     = 1'b1;
            w_ren_idx    = REN_A;
            w_state_next = ST_T2;
          end
          OP_LD: begin
            // mem_ready is deliberately not looked at until MEMW.
            w_mem_req    = 1'b1;
            w_state_next = ST_MEMW;
          end
          OP_BEQZ: begin
            w_branch     = bus.zero;
            w_done       = 1'b1;
            w_state_next = ST_FETCH;
          end
          OP_JMP: begin
            w_branch     = 1'b1;
            w_done       = 1'b1;
            w_state_next = ST_FETCH;
          end
          default: begin
            w_done       = 1'b1;
            w_state_next = ST_HALTED;
          end
        endcase
      end

      ST_T2: begin
        w_tri_en     = 1'b1;
        w_tri_idx    = TW'(w_ry);
        w_ren_en     = 1'b1;
        w_ren_idx    = REN_G;
        w_alu_op     = w_op[0];
        w_state_next = ST_T3;
      end

      ST_T3: begin
        w_tri_en     = 1'b1;
        w_tri_idx    = TRI_G;
        w_ren_en     = 1'b1;
        w_ren_idx    = RW'(w_rx);
        w_done       = 1'b1;
        w_state_next = ST_FETCH;
      end

      ST_MEMW: begin
        w_mem_req = 1'b1;
        if (bus.mem_ready) begin
          w_tri_en     = 1'b1;
          w_tri_idx    = TRI_MEM;
          w_ren_en     = 1'b1;
          w_ren_idx    = RW'(w_rx);
          w_done       = 1'b1;
          w_state_next = ST_FETCH;
        end
      end

      ST_HALTED: begin
        w_halted = 1'b1;
        if (bus.start) begin
          w_state_next = ST_FETCH;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  onehot_dec #(.N(NREG + 2)) u_ren_dec (
    .i_idx (w_ren_idx),
    .i_en  (w_ren_en),
    .o_oh  (w_r_en_oh)
  );

  onehot_dec #(.N(NREG + 3)) u_tri_dec (
    .i_idx (w_tri_idx),
    .i_en  (w_tri_en),
    .o_oh  (w_tri_oh)
  );

  assign bus.r_en_oh = w_r_en_oh;
  assign bus.tri_oh  = w_tri_oh;
  assign bus.ir_ld   = w_ir_ld;
  assign bus.inc_pc  = w_inc_pc;
  assign bus.branch  = w_branch;
  assign bus.alu_op  = w_alu_op;
  assign bus.mem_req = w_mem_req;
  assign bus.done    = w_done;
  assign bus.halted  = w_halted;

endmodule
